// File: rtl/bcd_to_7sd_pkg.sv
// Shared segment patterns for the BCD to seven-segment decoder.
// Patterns are active-high "lit" vectors ordered {A, B, C, D, E, F, G}.
package bcd_to_7sd_pkg;

    localparam logic [6:0] SEG_0      = 7'b1111110;
    localparam logic [6:0] SEG_1      = 7'b0110000;
    localparam logic [6:0] SEG_2      = 7'b1101101;
    localparam logic [6:0] SEG_3      = 7'b1111001;
    localparam logic [6:0] SEG_4      = 7'b0110011;
    localparam logic [6:0] SEG_5      = 7'b1011011;
    localparam logic [6:0] SEG_6      = 7'b1011111;
    localparam logic [6:0] SEG_7      = 7'b1110000;
    localparam logic [6:0] SEG_8      = 7'b1111111;
    localparam logic [6:0] SEG_9      = 7'b1111011;
    localparam logic [6:0] SEG_DASH   = 7'b0000001;
    localparam logic [6:0] SEG_BLANK  = 7'b0000000;
    localparam logic [6:0] SEG_ALL_ON = 7'b1111111;

endpackage

// File: rtl/bcd_seg_lut.sv
// Combinational BCD digit to lit-segment lookup; codes 10-15 map to a dash or blank.
module bcd_seg_lut
    import bcd_to_7sd_pkg::*;
#(
    parameter bit INVALID_DASH = 1'b1
) (
    input  logic [3:0] bcd,
    output logic [6:0] lit
);

    always_comb begin
        lit = SEG_BLANK;
        case (bcd)
            4'd0:    lit = SEG_0;
            4'd1:    lit = SEG_1;
            4'd2:    lit = SEG_2;
            4'd3:    lit = SEG_3;
            4'd4:    lit = SEG_4;
            4'd5:    lit = SEG_5;
            4'd6:    lit = SEG_6;
            4'd7:    lit = SEG_7;
            4'd8:    lit = SEG_8;
            4'd9:    lit = SEG_9;
            default: lit = INVALID_DASH ? SEG_DASH : SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_to_7sd.sv
// Registered BCD to seven-segment driver with lamp test, blanking and decimal point.
// Tie en, lt_n and bi_n high and dp_in low when those features are unused.
module bcd_to_7sd
    import bcd_to_7sd_pkg::*;
#(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter bit INVALID_DASH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd,
    input  logic       en,
    input  logic       lt_n,
    input  logic       bi_n,
    input  logic       dp_in,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic       DP
);

    localparam logic [7:0] UNLIT = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [6:0] lut_lit;
    logic [7:0] lit_d;
    logic [7:0] seg_d;
    logic [7:0] seg_q;

    bcd_seg_lut #(
        .INVALID_DASH(INVALID_DASH)
    ) u_lut (
        .bcd(bcd),
        .lit(lut_lit)
    );

    // Lamp test beats blanking, which beats the decoded digit and DP request.
    always_comb begin
        lit_d = {lut_lit, dp_in};
        if (!lt_n) begin
            lit_d = {SEG_ALL_ON, 1'b1};
        end else if (!bi_n) begin
            lit_d = {SEG_BLANK, 1'b0};
        end
        seg_d = ACTIVE_LOW ? ~lit_d : lit_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= UNLIT;
        end else if (en) begin
            seg_q <= seg_d;
        end
    end

    assign {A, B, C, D, E, F, G, DP} = seg_q;

endmodule

// File: tb/tb_bcd_to_7sd.sv
// Self-checking bench: table of vectors with a scoreboard queue, driving three decoder variants.
module tb_bcd_to_7sd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] bcd = 4'd0;
    logic       en = 1'b1;
    logic       lt_n = 1'b1;
    logic       bi_n = 1'b1;
    logic       dp_in = 1'b0;
    logic [7:0] o_def;
    logic [7:0] o_nd;
    logic [7:0] o_ah;

    always #5 clk = ~clk;

    bcd_to_7sd #(.ACTIVE_LOW(1'b1), .INVALID_DASH(1'b1)) dut_def (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .en(en), .lt_n(lt_n), .bi_n(bi_n),
        .dp_in(dp_in), .A(o_def[7]), .B(o_def[6]), .C(o_def[5]), .D(o_def[4]),
        .E(o_def[3]), .F(o_def[2]), .G(o_def[1]), .DP(o_def[0])
    );

    bcd_to_7sd #(.ACTIVE_LOW(1'b1), .INVALID_DASH(1'b0)) dut_nd (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .en(en), .lt_n(lt_n), .bi_n(bi_n),
        .dp_in(dp_in), .A(o_nd[7]), .B(o_nd[6]), .C(o_nd[5]), .D(o_nd[4]),
        .E(o_nd[3]), .F(o_nd[2]), .G(o_nd[1]), .DP(o_nd[0])
    );

    bcd_to_7sd #(.ACTIVE_LOW(1'b0), .INVALID_DASH(1'b1)) dut_ah (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .en(en), .lt_n(lt_n), .bi_n(bi_n),
        .dp_in(dp_in), .A(o_ah[7]), .B(o_ah[6]), .C(o_ah[5]), .D(o_ah[4]),
        .E(o_ah[3]), .F(o_ah[2]), .G(o_ah[1]), .DP(o_ah[0])
    );

    typedef struct {
        logic [3:0] bcd;
        logic       en;
        logic       lt_n;
        logic       bi_n;
        logic       dp_in;
        logic [7:0] exp;   // {A..G, DP} for the default (active-low, dash) variant
        string      name;
    } vec_t;

    typedef struct {
        logic [23:0] exp;  // {default, no-dash, active-high}
        string       name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0]  st_nd;
    logic [7:0]  st_ah;
    logic [23:0] cur;

    function automatic logic [6:0] ref_lut(input logic [3:0] d, input bit dash);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return dash ? 7'b0000001 : 7'b0000000;
        endcase
    endfunction

    function automatic logic [7:0] ref_out(input vec_t v, input bit dash, input bit al);
        logic [7:0] lit;
        if (!v.lt_n)      lit = 8'hFF;
        else if (!v.bi_n) lit = 8'h00;
        else              lit = {ref_lut(v.bcd, dash), v.dp_in};
        return al ? ~lit : lit;
    endfunction

    function automatic vec_t mk(input logic [3:0] b, input logic e, input logic lt,
                                input logic bi, input logic dp, input logic [7:0] x,
                                input string n);
        vec_t v;
        v.bcd = b; v.en = e; v.lt_n = lt; v.bi_n = bi; v.dp_in = dp; v.exp = x; v.name = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; drives, checks no early change, then checks the result.
    task automatic step(input vec_t v);
        sb_t e;
        bcd = v.bcd; en = v.en; lt_n = v.lt_n; bi_n = v.bi_n; dp_in = v.dp_in;
        if (v.en) begin
            st_nd = ref_out(v, 1'b0, 1'b1);
            st_ah = ref_out(v, 1'b1, 1'b0);
        end
        e.exp = {v.exp, st_nd, st_ah};
        e.name = v.name;
        sbq.push_back(e);
        #1;
        check({v.name, "/pre_edge"}, {o_def, o_nd, o_ah}, cur);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check({v.name, "/scoreboard_empty"}, 24'h0, 24'h1);
        end else begin
            e = sbq.pop_front();
            check(e.name, {o_def, o_nd, o_ah}, e.exp);
            cur = e.exp;
        end
    endtask

    initial begin
        vecs.push_back(mk(4'd0,  1, 1, 1, 0, 8'b0000_0011, "dig0"));
        vecs.push_back(mk(4'd1,  1, 1, 1, 0, 8'b1001_1111, "dig1"));
        vecs.push_back(mk(4'd2,  1, 1, 1, 0, 8'b0010_0101, "dig2"));
        vecs.push_back(mk(4'd3,  1, 1, 1, 0, 8'b0000_1101, "dig3"));
        vecs.push_back(mk(4'd4,  1, 1, 1, 0, 8'b1001_1001, "dig4"));
        vecs.push_back(mk(4'd5,  1, 1, 1, 0, 8'b0100_1001, "dig5"));
        vecs.push_back(mk(4'd6,  1, 1, 1, 0, 8'b0100_0001, "dig6"));
        vecs.push_back(mk(4'd7,  1, 1, 1, 0, 8'b0001_1111, "dig7"));
        vecs.push_back(mk(4'd8,  1, 1, 1, 0, 8'b0000_0001, "dig8"));
        vecs.push_back(mk(4'd9,  1, 1, 1, 0, 8'b0000_1001, "dig9"));
        vecs.push_back(mk(4'd12, 1, 1, 1, 0, 8'b1111_1101, "inv12"));
        vecs.push_back(mk(4'd10, 1, 1, 1, 0, 8'b1111_1101, "inv10"));
        vecs.push_back(mk(4'd15, 1, 1, 1, 0, 8'b1111_1101, "inv15"));
        vecs.push_back(mk(4'd1,  1, 0, 0, 0, 8'b0000_0000, "lamp_test_wins"));
        vecs.push_back(mk(4'd1,  1, 1, 0, 1, 8'b1111_1111, "blank"));
        vecs.push_back(mk(4'd1,  1, 1, 1, 1, 8'b1001_1110, "dig1_dp"));
        vecs.push_back(mk(4'd12, 1, 0, 1, 0, 8'b0000_0000, "lamp_test_inv"));
        vecs.push_back(mk(4'd8,  1, 1, 1, 0, 8'b0000_0001, "load8"));
        vecs.push_back(mk(4'd3,  0, 1, 1, 0, 8'b0000_0001, "hold_en0"));
        vecs.push_back(mk(4'd3,  0, 0, 0, 1, 8'b0000_0001, "hold_lt_bi_ignored"));
        vecs.push_back(mk(4'd3,  1, 1, 1, 0, 8'b0000_1101, "reload3"));
        vecs.push_back(mk(4'd8,  1, 1, 1, 1, 8'b0000_0000, "load8_dp"));

        // Reset must act without a clock edge.
        #1 rst_n = 1'b0;
        #1 check("reset_async", {o_def, o_nd, o_ah}, {8'hFF, 8'hFF, 8'h00});
        @(posedge clk);
        #1 check("reset_held", {o_def, o_nd, o_ah}, {8'hFF, 8'hFF, 8'h00});
        rst_n = 1'b1;
        st_nd = 8'hFF;
        st_ah = 8'h00;
        cur = {8'hFF, 8'hFF, 8'h00};

        foreach (vecs[i]) step(vecs[i]);

        // Mid-operation reset overrides the loaded value immediately.
        rst_n = 1'b0;
        en = 1'b1;
        #1 check("reset_mid_op", {o_def, o_nd, o_ah}, {8'hFF, 8'hFF, 8'h00});
        #1 rst_n = 1'b1;
        st_nd = 8'hFF;
        st_ah = 8'h00;
        cur = {8'hFF, 8'hFF, 8'h00};
        step(mk(4'd7, 1, 1, 1, 0, 8'b0001_1111, "first_load_after_reset"));

        if (sbq.size() != 0) check("scoreboard_drained", 24'(sbq.size()), 24'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
